// File: rtl/fifo_async.sv
// Single-clock FWFT FIFO with registered counts, reset-busy window and optional status pulses.
// Define FIFO_ASYNC_STATUS_EN to enable wr_ack/overflow/underflow; otherwise they are tied low.
module fifo_async #(
  parameter int FIFO_WRITE_DEPTH = 512,
  parameter int WRITE_DATA_WIDTH = 128,
  parameter int RST_BUSY_CYCLES  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WRITE_DATA_WIDTH-1:0] din,
  output logic                        full,
  output logic                        almost_full,
  output logic                        wr_ack,
  output logic                        overflow,
  output logic [$clog2(FIFO_WRITE_DEPTH):0] wr_data_count,
  output logic                        wr_rst_busy,
  input  logic                        rd_en,
  output logic [WRITE_DATA_WIDTH-1:0] dout,
  output logic                        empty,
  output logic                        almost_empty,
  output logic                        data_valid,
  output logic                        underflow,
  output logic [$clog2(FIFO_WRITE_DEPTH):0] rd_data_count,
  output logic                        rd_rst_busy
);
  localparam int AW = $clog2(FIFO_WRITE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_WRITE_DEPTH);

  logic [WRITE_DATA_WIDTH-1:0] r_mem [FIFO_WRITE_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_busy;
  logic [3:0]    r_busy_cnt;

  logic w_empty;
  logic w_full;
  logic w_wr_acc;
  logic w_rd_acc;

  // Busy forces full, so writes are blocked during the reset window without extra gating.
  assign w_empty  = (r_count == '0);
  assign w_full   = r_busy | (r_count == DEPTH_C);
  assign w_wr_acc = wr_en & ~w_full;
  assign w_rd_acc = rd_en & ~w_empty & ~r_busy;

  // Storage has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_busy     <= 1'b1;
      r_busy_cnt <= 4'(RST_BUSY_CYCLES);
    end else begin
      // Counter reaches zero after RST_BUSY_CYCLES edges; busy drops on the following edge.
      if (r_busy) begin
        if (r_busy_cnt == 4'd0) begin
          r_busy <= 1'b0;
        end else begin
          r_busy_cnt <= r_busy_cnt - 4'd1;
        end
      end
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIFO_ASYNC_STATUS_EN
  logic r_wr_ack;
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= wr_en & w_full & ~r_busy;
      r_underflow <= rd_en & w_empty & ~r_busy;
    end
  end

  assign wr_ack    = r_wr_ack;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign wr_ack    = 1'b0;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign full          = w_full;
  assign almost_full   = ~r_busy & (r_count == DEPTH_C - CW'(1));
  assign empty         = w_empty;
  assign almost_empty  = (r_count == CW'(1));
  assign data_valid    = ~w_empty;
  assign dout          = w_empty ? '0 : r_mem[r_rd_ptr];
  assign wr_data_count = r_count;
  assign rd_data_count = r_count;
  assign wr_rst_busy   = r_busy;
  assign rd_rst_busy   = r_busy;

endmodule

// File: tb/tb_fifo_async.sv
// Directed bench for fifo_async at DEPTH=16, WIDTH=8, RST_BUSY_CYCLES=4.
module tb_fifo_async;
  localparam int DEPTH = 16;
  localparam int W     = 8;
  localparam int RBC   = 4;
  localparam int CW    = 5;

`ifdef FIFO_ASYNC_STATUS_EN
  localparam logic STAT = 1'b1;
`else
  localparam logic STAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [W-1:0]  din;
  logic          full;
  logic          almost_full;
  logic          wr_ack;
  logic          overflow;
  logic [CW-1:0] wr_data_count;
  logic          wr_rst_busy;
  logic          rd_en;
  logic [W-1:0]  dout;
  logic          empty;
  logic          almost_empty;
  logic          data_valid;
  logic          underflow;
  logic [CW-1:0] rd_data_count;
  logic          rd_rst_busy;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  fifo_async #(
    .FIFO_WRITE_DEPTH(DEPTH),
    .WRITE_DATA_WIDTH(W),
    .RST_BUSY_CYCLES (RBC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .full         (full),
    .almost_full  (almost_full),
    .wr_ack       (wr_ack),
    .overflow     (overflow),
    .wr_data_count(wr_data_count),
    .wr_rst_busy  (wr_rst_busy),
    .rd_en        (rd_en),
    .dout         (dout),
    .empty        (empty),
    .almost_empty (almost_empty),
    .data_valid   (data_valid),
    .underflow    (underflow),
    .rd_data_count(rd_data_count),
    .rd_rst_busy  (rd_rst_busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then stable for sampling and inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for busy to drop; returns number of busy cycles seen after the current one.
  task automatic wait_busy(output int n);
    n = 0;
    for (int g = 0; g < 40; g++) begin
      tick();
      if (wr_rst_busy) n++;
      else break;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    repeat (3) tick();
    rst = 1'b0;
    wait_busy(n);
    // One-cycle reset pulse: busy window is RBC+1 cycles long.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (wr_rst_busy !== 1'b1 || rd_rst_busy !== 1'b1 || full !== 1'b1 || empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags: busy=%b/%b full=%b empty=%b, required 1/1 1 1",
               wr_rst_busy, rd_rst_busy, full, empty);
    end
    checks++;
    if (wr_data_count !== 5'd0 || rd_data_count !== 5'd0 || dout !== 8'h00 ||
        almost_full !== 1'b0 || almost_empty !== 1'b0 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: wcnt=%0d rcnt=%0d dout=%h af=%b ae=%b dv=%b, required 0 0 00 0 0 0",
               wr_data_count, rd_data_count, dout, almost_full, almost_empty, data_valid);
    end
    checks++;
    if (wr_ack !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses: ack=%b ovf=%b unf=%b, required 0 0 0", wr_ack, overflow, underflow);
    end
    wait_busy(n);
    checks++;
    if (n + 1 !== RBC + 1) begin
      failures++;
      $display("FAIL busy_len: got %0d busy cycles, required %0d", n + 1, RBC + 1);
    end
    checks++;
    if (full !== 1'b0 || empty !== 1'b1 || rd_rst_busy !== 1'b0) begin
      failures++;
      $display("FAIL post_busy: full=%b empty=%b rd_busy=%b, required 0 1 0", full, empty, rd_rst_busy);
    end
  endtask

  task automatic test_single_write();
    wr_en = 1'b1; din = 8'hA5;
    tick();
    wr_en = 1'b0;
    checks++;
    if (empty !== 1'b0 || dout !== 8'hA5 || almost_empty !== 1'b1 || wr_data_count !== 5'd1 ||
        rd_data_count !== 5'd1 || data_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_write: empty=%b dout=%h ae=%b cnt=%0d/%0d dv=%b, required 0 a5 1 1/1 1",
               empty, dout, almost_empty, wr_data_count, rd_data_count, data_valid);
    end
    checks++;
    if (wr_ack !== STAT) begin
      failures++;
      $display("FAIL wr_ack: got %b, required %b", wr_ack, STAT);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (empty !== 1'b1 || wr_data_count !== 5'd0 || almost_empty !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL single_read: empty=%b cnt=%0d ae=%b unf=%b, required 1 0 0 0",
               empty, wr_data_count, almost_empty, underflow);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; din = W'(i);
      tick();
      checks++;
      if (wr_data_count !== CW'(i + 1) || almost_full !== (i + 1 == DEPTH - 1) ||
          full !== (i + 1 == DEPTH)) begin
        failures++;
        $display("FAIL fill[%0d]: cnt=%0d af=%b full=%b, required %0d %b %b", i, wr_data_count,
                 almost_full, full, i + 1, (i + 1 == DEPTH - 1), (i + 1 == DEPTH));
      end
    end
    din = 8'h77;
    tick();
    wr_en = 1'b0;
    checks++;
    if (overflow !== STAT || wr_ack !== 1'b0 || wr_data_count !== 5'd16 || full !== 1'b1) begin
      failures++;
      $display("FAIL overflow: ovf=%b ack=%b cnt=%0d full=%b, required %b 0 16 1",
               overflow, wr_ack, wr_data_count, full, STAT);
    end
    tick();
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear: got %b, required 0", overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dout !== W'(i) || empty !== 1'b0) begin
        failures++;
        $display("FAIL drain[%0d]: dout=%h empty=%b, required %h 0", i, dout, empty, W'(i));
      end
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    checks++;
    if (empty !== 1'b1 || wr_data_count !== 5'd0) begin
      failures++;
      $display("FAIL drain_end: empty=%b cnt=%0d, required 1 0", empty, wr_data_count);
    end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (underflow !== STAT || wr_data_count !== 5'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL underflow: unf=%b cnt=%0d empty=%b, required %b 0 1",
               underflow, wr_data_count, empty, STAT);
    end
    // Write into empty with rd_en: write wins, read is rejected.
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h3C;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (wr_data_count !== 5'd1 || dout !== 8'h3C || wr_ack !== STAT || underflow !== STAT) begin
      failures++;
      $display("FAIL wr_rd_empty: cnt=%0d dout=%h ack=%b unf=%b, required 1 3c %b %b",
               wr_data_count, dout, wr_ack, underflow, STAT, STAT);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL wr_rd_empty_drain: empty=%b unf=%b, required 1 0", empty, underflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v;
    for (int i = 0; i < 5; i++) begin
      v = W'(100 + i);
      wr_en = 1'b1; din = v;
      exp_q.push_back(v);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      v = W'($urandom_range(0, 255));
      checks++;
      if (dout !== exp_q[0]) begin
        failures++;
        $display("FAIL b2b_dout[%0d]: got %h, required %h", i, dout, exp_q[0]);
      end
      wr_en = 1'b1; rd_en = 1'b1; din = v;
      exp_q.push_back(v);
      void'(exp_q.pop_front());
      tick();
      checks++;
      if (wr_data_count !== 5'd5) begin
        failures++;
        $display("FAIL b2b_cnt[%0d]: got %0d, required 5", i, wr_data_count);
      end
    end
    wr_en = 1'b0;
    while (exp_q.size() > 0) begin
      checks++;
      if (dout !== exp_q[0]) begin
        failures++;
        $display("FAIL b2b_tail: got %h, required %h", dout, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
    end
    rd_en = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL b2b_empty: got %b, required 1", empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; din = W'(8'hC0 + i);
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (wr_data_count !== 5'd8) begin
      failures++;
      $display("FAIL mid_fill: cnt=%0d, required 8", wr_data_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_en = 1'b1; rd_en = 1'b1; din = 8'hEE;
    for (int g = 0; g < 40 && wr_rst_busy; g++) begin
      checks++;
      if (overflow !== 1'b0 || underflow !== 1'b0 || wr_ack !== 1'b0 || empty !== 1'b1) begin
        failures++;
        $display("FAIL mid_busy: ovf=%b unf=%b ack=%b empty=%b, required 0 0 0 1",
                 overflow, underflow, wr_ack, empty);
      end
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    checks++;
    if (wr_rst_busy !== 1'b0 || empty !== 1'b1 || wr_data_count !== 5'd0 || full !== 1'b0) begin
      failures++;
      $display("FAIL mid_after: busy=%b empty=%b cnt=%0d full=%b, required 0 1 0 0",
               wr_rst_busy, empty, wr_data_count, full);
    end
    tick();
    checks++;
    if (wr_ack !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || wr_data_count !== 5'd0) begin
      failures++;
      $display("FAIL mid_quiet: ack=%b ovf=%b unf=%b cnt=%0d, required 0 0 0 0",
               wr_ack, overflow, underflow, wr_data_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_async.md
FIFO_ASYNC -- requirements
Module: fifo_async

Interface
REQ-001 SHALL have parameter FIFO_WRITE_DEPTH, default 512, number of storage words (power of two, 16..4096).
REQ-002 SHALL have parameter WRITE_DATA_WIDTH, default 128, word width in bits (1..1024).
REQ-003 SHALL have parameter RST_BUSY_CYCLES, default 4, cycles that rst_busy stays high after rst falls (2..15).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 wr_en  input  1  write request.
REQ-008 din  input  WRITE_DATA_WIDTH  write data.
REQ-009 full  output  1  no free slot, or reset busy.
REQ-010 almost_full  output  1  exactly one free slot.
REQ-011 wr_ack  output  1  one-cycle pulse: previous-cycle write accepted.
REQ-012 overflow  output  1  one-cycle pulse: previous-cycle write rejected.
REQ-013 wr_data_count  output  log2(DEPTH)+1  stored-word count.
REQ-014 wr_rst_busy  output  1  reset in progress, write side.
REQ-015 rd_en  input  1  pop head word.
REQ-016 dout  output  WRITE_DATA_WIDTH  head word (first-word-fall-through).
REQ-017 empty  output  1  no word available.
REQ-018 almost_empty  output  1  exactly one word stored.
REQ-019 data_valid  output  1  dout holds a valid word; equals ~empty.
REQ-020 underflow  output  1  one-cycle pulse: previous-cycle read rejected.
REQ-021 rd_data_count  output  log2(DEPTH)+1  same value as wr_data_count.
REQ-022 rd_rst_busy  output  1  reset in progress, read side; equals wr_rst_busy.

Function
REQ-023 SHALL be FWFT: whenever empty=0, dout shows the oldest word with no rd_en needed.
REQ-024 A write accepted at edge N SHALL make empty=0 and dout valid after edge N (latency one cycle) if the FIFO was empty.
REQ-025 Write accepted iff wr_en=1, full=0, busy=0; a simultaneous read does not free space for it.
REQ-026 Read accepted iff rd_en=1, empty=0, busy=0; dout advances to the next word after the edge.
REQ-027 Simultaneous accepted read and write SHALL leave count unchanged; write to empty plus rd_en SHALL be write accepted, read rejected.
REQ-028 wr_en while full (not busy) SHALL not change storage and SHALL pulse overflow; rd_en while empty (not busy) SHALL pulse underflow.
REQ-029 Counts SHALL be registered, 0..DEPTH; full=(count==DEPTH), almost_full=(count==DEPTH-1), almost_empty=(count==1).
REQ-030 Pointers SHALL wrap modulo DEPTH with no lost or duplicated word.

Reset
REQ-031 rst sampled high SHALL clear pointers/counts, force empty=1, full=1, almost flags 0, pulses 0, dout=0, both busy=1 from the next cycle.
REQ-032 busy SHALL remain 1 while rst=1 and for RST_BUSY_CYCLES cycles after rst is first sampled low, then full falls to 0.
REQ-033 rst mid-operation SHALL discard all stored words; wr_en/rd_en during busy are ignored without overflow/underflow.

Configuration
REQ-034 Macro FIFO_ASYNC_STATUS_EN defined: wr_ack, overflow, underflow behave as specified.
REQ-035 Macro undefined: those three ports exist but are tied to 0; all other behaviour unchanged.

Verification
REQ-036 Pulse rst 1 cycle -> busy=1 for exactly RST_BUSY_CYCLES+1 cycles, full 1 then 0, empty=1, counts 0.
REQ-037 Write 0xA5 (DEPTH=16) into empty FIFO -> next cycle empty=0, dout=0xA5, almost_empty=1, count=1; rd_en -> empty=1.
REQ-038 Write 16 words 0..15 -> full=1 at count 16, almost_full at 15; 17th write -> overflow pulse, count stays 16; read all -> 0..15 in order.
REQ-039 Read when empty -> underflow pulse, count 0; write+read each cycle for 40 cycles at count 5 -> count stays 5, order preserved across wrap.
REQ-040 Assert rst with 8 words stored -> empty=1, count 0 after busy; with FIFO_ASYNC_STATUS_EN undefined, overflow/underflow/wr_ack stay 0.
